// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster pixel stream to 3x3 neighbourhood with in-frame valid and centre position
module window_3x3_gen #(
  parameter int DATA_WIDTH = 14,
  parameter int IMG_WIDTH  = 100,
  parameter int IMG_HEIGHT = 100
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          win_valid,
  output logic [9*DATA_WIDTH-1:0]       window,
  output logic [$clog2(IMG_HEIGHT)-1:0] centre_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  centre_col,
  output logic                          frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DATA_WIDTH-1:0] l0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] l1 [IMG_WIDTH];
  logic [8:0][DATA_WIDTH-1:0] win_q;
  logic acc, col_last, row_last, full;
  always_comb begin
    acc      = in_valid && !Rst;
    col_last = col == CW'(IMG_WIDTH - 1);
    row_last = row == RW'(IMG_HEIGHT - 1);
    full     = row >= RW'(2) && col >= CW'(2);
  end
  // Line memories are never reset; rows 0-1 and cols 0-1 never produce a window, hiding stale data
  always_ff @(posedge Clk)
    if (acc) begin
      l1[col] <= l0[col];
      l0[col] <= data_in;
    end
  always_ff @(posedge Clk)
    if (Rst) begin
      col        <= '0;
      row        <= '0;
      win_q      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      centre_row <= '0;
      centre_col <= '0;
    end else begin
      win_valid  <= acc && full;
      frame_done <= acc && row_last && col_last;
      if (acc) begin
        win_q <= {data_in, win_q[8:7], l0[col], win_q[5:4], l1[col], win_q[2:1]};
        col   <= col_last ? '0 : col + CW'(1);
        if (col_last) row <= row_last ? '0 : row + RW'(1);
        if (full) begin
          centre_row <= row - RW'(1);
          centre_col <= col - CW'(1);
        end
      end
    end
  assign window = win_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: random-stimulus check of window_3x3_gen against an image-array reference model
module tb_window_3x3_gen;
  localparam int DW = 14;
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [DW-1:0] data_in;
  logic [2:0] wv, fd;
  logic [9*DW-1:0] win [3];
  logic [1:0] cr4, cc4, cr3, cc3;
  logic [6:0] cr100, cc100;
  int sel, mw, mh, mr, mc;
  int checks = 0, errors = 0, n_win, n_fd;
  logic [DW-1:0] img [100][100];
  logic ev, efd, erst;
  logic [8:0][DW-1:0] ew;
  int ecr, ecc;

  always #5 clk = ~clk;

  window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u4 (
    .Clk(clk), .Rst(rst), .in_valid(in_valid), .data_in(data_in), .win_valid(wv[0]),
    .window(win[0]), .centre_row(cr4), .centre_col(cc4), .frame_done(fd[0]));
  window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) u3 (
    .Clk(clk), .Rst(rst), .in_valid(in_valid), .data_in(data_in), .win_valid(wv[1]),
    .window(win[1]), .centre_row(cr3), .centre_col(cc3), .frame_done(fd[1]));
  window_3x3_gen #(.DATA_WIDTH(DW)) u100 (
    .Clk(clk), .Rst(rst), .in_valid(in_valid), .data_in(data_in), .win_valid(wv[2]),
    .window(win[2]), .centre_row(cr100), .centre_col(cc100), .frame_done(fd[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (sel=%0d r=%0d c=%0d)", tag, got, exp, sel, mr, mc);
    end
  endtask

  task automatic use_dut(input int s);
    sel = s;
    mw = s == 0 ? 4 : s == 1 ? 3 : 100;
    mh = mw;
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    logic [127:0] gwin;
    int gcr, gcc;
    rst = r; in_valid = v; data_in = d;
    erst = r; ev = 1'b0; efd = 1'b0;
    if (r) begin
      mr = 0; mc = 0;
    end else if (v) begin
      img[mr][mc] = d;
      ev  = mr >= 2 && mc >= 2;
      efd = mr == mh - 1 && mc == mw - 1;
      if (ev) begin
        for (int k = 0; k < 9; k++) ew[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
        ecr = mr - 1; ecc = mc - 1;
      end
      mc = mc + 1;
      if (mc == mw) begin
        mc = 0;
        mr = mr == mh - 1 ? 0 : mr + 1;
      end
    end
    @(posedge clk); #1;
    gwin = 128'(win[sel]);
    gcr = sel == 0 ? int'(cr4) : sel == 1 ? int'(cr3) : int'(cr100);
    gcc = sel == 0 ? int'(cc4) : sel == 1 ? int'(cc3) : int'(cc100);
    if (wv[sel]) n_win++;
    if (fd[sel]) n_fd++;
    chk("win_valid", 128'(wv[sel]), 128'(ev));
    chk("frame_done", 128'(fd[sel]), 128'(efd));
    if (ev) begin
      chk("window", gwin, 128'(ew));
      chk("centre_row", 128'(gcr), 128'(ecr));
      chk("centre_col", 128'(gcc), 128'(ecc));
    end
    if (erst) begin
      chk("rst_window", gwin, 128'(0));
      chk("rst_centre", 128'({gcr, gcc}), 128'(0));
    end
  endtask

  task automatic reset_all();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    n_win = 0; n_fd = 0;
  endtask

  task automatic frame(input int base, input int gap_mode, input logic rnd_pix);
    for (int p = 0; p < mw * mh; p++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))
        repeat (gap_mode == 1 ? 1 : $urandom_range(1, 3)) step(1'b0, DW'($urandom), 1'b0);
      step(1'b1, rnd_pix ? DW'($urandom) : DW'(base + p), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; data_in = '0;
    use_dut(0);
    reset_all();
    frame(0, 0, 1'b0);
    chk("t1_windows", 128'(n_win), 128'(4));
    chk("t1_frame_done", 128'(n_fd), 128'(1));
    reset_all();
    frame(0, 1, 1'b0);
    frame(0, 2, 1'b0);
    chk("t2_windows", 128'(n_win), 128'(8));
    reset_all();
    frame(0, 0, 1'b0);
    frame(100, 0, 1'b0);
    chk("t3_frame_done", 128'(n_fd), 128'(2));
    reset_all();
    for (int p = 0; p < 10; p++) step(1'b1, DW'(p), 1'b0);
    step(1'b1, DW'(55), 1'b1);
    n_win = 0; n_fd = 0;
    frame(0, 2, 1'b0);
    chk("t4_windows", 128'(n_win), 128'(4));
    use_dut(2);
    reset_all();
    frame(0, 2, 1'b1);
    chk("t5_windows", 128'(n_win), 128'(9604));
    chk("t5_frame_done", 128'(n_fd), 128'(1));
    use_dut(1);
    reset_all();
    frame(0, 0, 1'b1);
    frame(0, 2, 1'b1);
    chk("t6_windows", 128'(n_win), 128'(2));
    chk("t6_frame_done", 128'(n_fd), 128'(2));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
